cpu_fetch: RTL and testbench
============================

# cpu_fetch

Instruction fetch unit for the 16-bit CPU. It holds the program counter and reads instruction words from instruction memory as an APB read-only requester. It delivers each word as `IR` to the CPU control decoder and takes PC redirects from the control path. It drives the same APB bus the control unit's `apb_bus_ctrl` targets, from the instruction side.

## Interface
- `RESET_PC`, 16'h0000: PC value loaded on reset.
- `TIMEOUT`, 16: maximum ACCESS-phase wait cycles. Used only when `CPU_FETCH_TIMEOUT_EN` is defined.

Ports:
- `clk`  in  1  single clock; all logic on posedge.
- `reset`  in  1  synchronous, active-low (0 = reset, sampled on posedge `clk`).
- `stall`  in  1  1 = do not start a new fetch; hold `IR`.
- `branch_taken`  in  1  1-cycle redirect request (control `PC_sel`).
- `branch_target`  in  16  new PC, valid with `branch_taken`.
- `psel`, `penable`  out  1  APB control.
- `pwrite`  out  1  tied 0.
- `paddr`  out  16  word address = PC.
- `prdata`  in  16  instruction word.
- `pready`, `pslverr`  in  1  APB completion / error.
- `IR`  out  16  current instruction.
- `ir_valid`  out  1  1-cycle pulse when `IR` is loaded.
- `pc`  out  16  address of the instruction in `IR`.
- `fetch_err`  out  1  sticky error flag; cleared only by reset.

## Operation
- FSM states: IDLE, SETUP, ACCESS.
- IDLE: if `stall`=0, go to SETUP with `paddr`=PC.
- SETUP: `psel`=1, `penable`=0. Always go to ACCESS.
- ACCESS: `psel`=1, `penable`=1. Hold while `pready`=0.
- On `pready`=1 with no kill (see redirect):
  - `IR`<=`prdata`, `pc`<=PC, PC<=PC+1 (16-bit wrap, FFFF->0000), `ir_valid` pulses.
  - If `pslverr`=1: `IR`<=NOP (16'h0000) instead of `prdata`; `fetch_err`<=1; PC still increments.
  - Next state: SETUP if `stall`=0, else IDLE.
- Redirect:
  - `branch_taken` in IDLE or SETUP: PC<=`branch_target`. A redirect in SETUP does not change the current transfer's `paddr`; that transfer is killed.
  - `branch_taken` in ACCESS: PC<=`branch_target`; the in-flight transfer is marked killed and still runs to `pready`. APB transfers are never aborted.
  - A killed transfer's data is discarded: no `IR` load, no `ir_valid`, no PC increment.
  - Kill flag clears when the killed transfer completes.
- Simultaneous events:
  - `branch_taken` in the same cycle as `pready`: discard, PC<=target, next SETUP uses target.
  - `branch_taken` with `stall`: PC updates, FSM goes to or stays in IDLE.
  - `stall` asserted mid-transfer: the transfer completes normally; no new SETUP.
- `paddr` and `psel` remain stable throughout SETUP/ACCESS.

## Timing
- Reset values: FSM=IDLE, `psel`=`penable`=`pwrite`=0, `paddr`=`RESET_PC`, PC=`RESET_PC`, `IR`=16'h0000, `pc`=`RESET_PC`, `ir_valid`=0, `fetch_err`=0, kill=0.
- Zero-wait fetch: SETUP at cycle N, ACCESS at N+1 with `pready`=1, `IR`/`ir_valid` visible at N+2.
- Throughput: one instruction per 2 cycles with back-to-back transfers (ACCESS->SETUP, no IDLE cycle).
- Each `pready`=0 cycle adds 1 cycle of latency.
- First SETUP after reset release: the cycle after `reset` is first sampled 1 with `stall`=0.
- Reset mid-transfer: `psel`/`penable` drop at that edge. The slave shares the same reset.

## Configuration
- `CPU_FETCH_TIMEOUT_EN` defined:
  - A wait counter runs in ACCESS and clears on entering ACCESS.
  - If `TIMEOUT` consecutive cycles pass with `pready`=0, the transfer ends as if `pslverr`=1: NOP loaded, `fetch_err`=1, PC+1, `psel`/`penable` drop.
  - A killed transfer that times out just drops; no `IR` load.
- Undefined: no counter; ACCESS waits indefinitely for `pready`.

## Structure
- `cpu_pkg` holds:
  - `fetch_state_t` enum (IDLE/SETUP/ACCESS)
  - `NOP_INSTR` = 16'h0000 (ADD r0,r0,r0)
  - `opcode_t` 3-bit enum shared with the control decoder
  - the `IR` field slice constants.
- One sub-module, `apb_rd_master`: SETUP/ACCESS sequencing and the optional timeout. It reports done, data, and err to the `cpu_fetch` top level. `cpu_fetch` owns PC, kill, and `IR`.

## Test plan
- Reset, `stall`=0, `pready`=1 always, mem[0..2]=16'h2081/16'h4112/16'h6223 -> `paddr` 0,1,2 every 2 cycles; `IR` sequence matches; `ir_valid` pulses at cycles 2, 4, 6; `pc`=0,1,2.
- `pready` held low 3 cycles on address 5 -> `psel`/`penable`/`paddr` stable for 4 ACCESS cycles; `IR` loads mem[5] one cycle after `pready`.
- `branch_taken`, target 16'h0040, during ACCESS of address 3 with 2 wait states -> mem[3] discarded, no `ir_valid`; next `paddr`=16'h0040.
- `stall`=1 mid-transfer at address 7 -> mem[7] loaded, FSM to IDLE, no SETUP until `stall`=0; `IR` held.
- `pslverr`=1 at address 9 -> `IR`=16'h0000, `fetch_err`=1 (stays 1), next `paddr`=10. With the macro: `pready` never asserted -> same response after `TIMEOUT` cycles.
- PC=16'hFFFF fetch, then `reset` low during ACCESS -> wrap to 16'h0000 observed; after reset, `paddr`=`RESET_PC` and all outputs at reset values.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM states, NOP encoding, opcode enum and
// instruction-register field positions used by the fetch unit and decoder.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } fetch_state_t;

    // ADD r0,r0,r0 -- architecturally a no-op, substituted for faulted fetches.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_LW  = 3'd4,
        OP_SW  = 3'd5,
        OP_BEQ = 3'd6,
        OP_JMP = 3'd7
    } opcode_t;

    // IR field layout: [15:13] opcode, [12:10] rd, [9:7] rs, [6:4] rt.
    localparam int OPCODE_MSB = 15;
    localparam int OPCODE_LSB = 13;
    localparam int RD_MSB     = 12;
    localparam int RD_LSB     = 10;
    localparam int RS_MSB     = 9;
    localparam int RS_LSB     = 7;
    localparam int RT_MSB     = 6;
    localparam int RT_LSB     = 4;

    function automatic opcode_t ir_opcode(input logic [15:0] ir);
        return opcode_t'(ir[OPCODE_MSB:OPCODE_LSB]);
    endfunction

endpackage

// File: rtl/cpu_fetch_if.sv
// APB bus seen from the instruction side: the fetch unit is the requester
// (master modport), instruction memory is the completer (slave modport).
interface cpu_fetch_if;
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [15:0] paddr;
    logic [15:0] prdata;
    logic        pready;
    logic        pslverr;

    modport master (
        output psel, penable, pwrite, paddr,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/cpu_fetch_apb_rd_master.sv
// Read-only APB requester: IDLE/SETUP/ACCESS sequencing, paddr capture and,
// when CPU_FETCH_TIMEOUT_EN is defined, an ACCESS-phase wait-state timeout.
// Reports each completed transfer to the owner via done/rdata/err.
module apb_rd_master
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
`ifdef CPU_FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,       // begin (or chain) a transfer
    input  logic [15:0] start_addr,  // address for the next SETUP
    output logic        busy,        // a transfer is in SETUP or ACCESS
    output logic        done,        // ACCESS completes this cycle
    output logic [15:0] rdata,
    output logic        err,         // slave error or timeout on completion
    cpu_fetch_if.master bus
);

    fetch_state_t state, state_nxt;
    logic         timeout;

`ifdef CPU_FETCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] wait_cnt;

    // Count consecutive not-ready ACCESS cycles; zero outside ACCESS so each
    // transfer starts its budget fresh.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
        end else if (state != ACCESS) begin
            wait_cnt <= '0;
        end else if (!bus.pready) begin
            wait_cnt <= wait_cnt + CW'(1);
        end
    end

    assign timeout = (state == ACCESS) && !bus.pready &&
                     (wait_cnt == CW'(TIMEOUT - 1));
`else
    assign timeout = 1'b0;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and APB control decode.
    // NOTE: every output gets a default first so no path leaves a signal
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt   = state;
        bus.psel    = 1'b0;
        bus.penable = 1'b0;
        done        = 1'b0;
        err         = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = SETUP;
            end
            SETUP: begin
                bus.psel  = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                bus.psel    = 1'b1;
                bus.penable = 1'b1;
                if (bus.pready || timeout) begin
                    done      = 1'b1;
                    err       = timeout || bus.pslverr;
                    state_nxt = start ? SETUP : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // paddr is captured only when a SETUP is about to begin, so it stays
    // stable across SETUP and every ACCESS wait cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.paddr <= RESET_PC;
        end else if (start && ((state == IDLE) || done)) begin
            bus.paddr <= start_addr;
        end
    end

    assign bus.pwrite = 1'b0;
    assign busy       = (state != IDLE);
    assign rdata      = bus.prdata;

endmodule

// File: rtl/cpu_fetch.sv
// Instruction fetch unit: owns PC, the redirect kill flag and IR; uses
// apb_rd_master for bus sequencing. Optional feature macro:
// CPU_FETCH_TIMEOUT_EN (ACCESS wait-state timeout, treated as slave error).
module cpu_fetch
    import cpu_pkg::*;
#(
    parameter logic [15:0] RESET_PC = 16'h0000
`ifdef CPU_FETCH_TIMEOUT_EN
    ,
    parameter int TIMEOUT = 16
`endif
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [15:0] branch_target,
    cpu_fetch_if.master bus,
    output logic [15:0] IR,
    output logic        ir_valid,
    output logic [15:0] pc,
    output logic        fetch_err
);

    logic [15:0] fetch_pc;   // address of the next (or in-flight) fetch
    logic [15:0] pc_nxt;
    logic        kill;
    logic        start, busy, done, err, discard, accept;
    logic [15:0] rdata;

    assign start   = !stall;
    // A redirect arriving with completion discards that word just like a
    // redirect arriving earlier in the transfer.
    assign discard = kill || branch_taken;
    assign accept  = done && !discard;

    // Next PC: redirect wins, otherwise advance only on an accepted word.
    always_comb begin
        pc_nxt = fetch_pc;
        if (accept)       pc_nxt = fetch_pc + 16'd1;
        if (branch_taken) pc_nxt = branch_target;
    end

    apb_rd_master #(
        .RESET_PC (RESET_PC)
`ifdef CPU_FETCH_TIMEOUT_EN
        ,
        .TIMEOUT  (TIMEOUT)
`endif
    ) u_apb_rd_master (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .start_addr (pc_nxt),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .err        (err),
        .bus        (bus)
    );

    // PC, kill flag, IR and status updates.
    always_ff @(posedge clk) begin
        if (!reset) begin
            fetch_pc  <= RESET_PC;
            kill      <= 1'b0;
            IR        <= NOP_INSTR;
            ir_valid  <= 1'b0;
            pc        <= RESET_PC;
            fetch_err <= 1'b0;
        end else begin
            fetch_pc <= pc_nxt;
            ir_valid <= accept;
            if (done) begin
                kill <= 1'b0;
            end else if (branch_taken && busy) begin
                kill <= 1'b1;
            end
            if (accept) begin
                IR <= err ? NOP_INSTR : rdata;
                pc <= fetch_pc;
                if (err) fetch_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_fetch.sv
// Directed testbench for cpu_fetch with a behavioural APB instruction memory.
module tb_cpu_fetch;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_target;
    logic [15:0] IR;
    logic        ir_valid;
    logic [15:0] pc;
    logic        fetch_err;
    logic        ready_ctl;
    logic        err_ctl;
    logic [15:0] mem [0:255];

    int tests  = 0;
    int failed = 0;

    cpu_fetch_if bus ();

    cpu_fetch dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .bus           (bus),
        .IR            (IR),
        .ir_valid      (ir_valid),
        .pc            (pc),
        .fetch_err     (fetch_err)
    );

    // Instruction memory slave: combinational read, bench-controlled handshake.
    assign bus.prdata  = mem[bus.paddr[7:0]];
    assign bus.pready  = ready_ctl;
    assign bus.pslverr = err_ctl;

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, then redirect while stalled in IDLE, then release into SETUP at a.
    task automatic start_at(input logic [15:0] a);
        reset = 1'b0; stall = 1'b1; branch_taken = 1'b0; branch_target = 16'h0;
        ready_ctl = 1'b1; err_ctl = 1'b0;
        tick(); tick();
        reset = 1'b1; branch_taken = 1'b1; branch_target = a;
        tick();
        tests++;
        if (bus.psel !== 1'b0) begin
            failed++; $display("FAIL branch_stall_idle: psel=%b expected 0", bus.psel);
        end
        branch_taken = 1'b0; stall = 1'b0;
        tick();
        tests++;
        if ({bus.psel, bus.penable, bus.paddr} !== {2'b10, a}) begin
            failed++; $display("FAIL start_setup: got %h expected %h",
                               {bus.psel, bus.penable, bus.paddr}, {2'b10, a});
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 16'h0;
        ready_ctl = 1'b1; err_ctl = 1'b0;
        tick(); tick();
        tests++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.paddr} !== {3'b000, 16'h0000}) begin
            failed++; $display("FAIL reset_bus: got %h expected %h",
                               {bus.psel, bus.penable, bus.pwrite, bus.paddr}, {3'b000, 16'h0000});
        end
        tests++;
        if ({IR, ir_valid, pc, fetch_err} !== {16'h0000, 1'b0, 16'h0000, 1'b0}) begin
            failed++; $display("FAIL reset_out: got %h expected %h",
                               {IR, ir_valid, pc, fetch_err}, {16'h0000, 1'b0, 16'h0000, 1'b0});
        end
    endtask

    task automatic test_sequential();
        logic [15:0] exp_ir [3];
        exp_ir[0] = 16'h2081; exp_ir[1] = 16'h4112; exp_ir[2] = 16'h6223;
        reset = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            tests++;
            if ({bus.psel, bus.penable, bus.paddr} !== {2'b10, 16'(k)}) begin
                failed++; $display("FAIL seq_setup%0d: got %h expected %h", k,
                                   {bus.psel, bus.penable, bus.paddr}, {2'b10, 16'(k)});
            end
            tick();
            tests++;
            if ({bus.psel, bus.penable, bus.paddr, ir_valid} !== {2'b11, 16'(k), 1'b0}) begin
                failed++; $display("FAIL seq_access%0d: got %h expected %h", k,
                                   {bus.psel, bus.penable, bus.paddr, ir_valid}, {2'b11, 16'(k), 1'b0});
            end
            tick();
            tests++;
            if ({ir_valid, IR, pc} !== {1'b1, exp_ir[k], 16'(k)}) begin
                failed++; $display("FAIL seq_ir%0d: got %h expected %h", k,
                                   {ir_valid, IR, pc}, {1'b1, exp_ir[k], 16'(k)});
            end
        end
    endtask

    // Continues from test_sequential: SETUP of address 3 is on the bus.
    task automatic test_branch_in_access();
        ready_ctl = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i == 0); branch_target = 16'h0040; ready_ctl = (i == 2);
            tests++;
            if ({bus.psel, bus.penable, bus.paddr, ir_valid, IR} !==
                {2'b11, 16'h0003, 1'b0, 16'h6223}) begin
                failed++; $display("FAIL kill_access%0d: got %h expected %h", i,
                                   {bus.psel, bus.penable, bus.paddr, ir_valid, IR},
                                   {2'b11, 16'h0003, 1'b0, 16'h6223});
            end
            tick();
        end
        branch_taken = 1'b0;
        tests++;
        if ({bus.psel, bus.penable, bus.paddr, ir_valid, IR, pc} !==
            {2'b10, 16'h0040, 1'b0, 16'h6223, 16'h0002}) begin
            failed++; $display("FAIL kill_discard: got %h expected %h",
                               {bus.psel, bus.penable, bus.paddr, ir_valid, IR, pc},
                               {2'b10, 16'h0040, 1'b0, 16'h6223, 16'h0002});
        end
        tick(); tick();
        tests++;
        if ({ir_valid, IR, pc} !== {1'b1, 16'h40BF, 16'h0040}) begin
            failed++; $display("FAIL kill_target_ir: got %h expected %h",
                               {ir_valid, IR, pc}, {1'b1, 16'h40BF, 16'h0040});
        end
    endtask

    task automatic test_branch_at_ready();
        start_at(16'h0020);
        tick();
        branch_taken = 1'b1; branch_target = 16'h0030; ready_ctl = 1'b1;
        tick();
        branch_taken = 1'b0;
        tests++;
        if ({bus.psel, bus.penable, bus.paddr, ir_valid, IR} !==
            {2'b10, 16'h0030, 1'b0, 16'h0000}) begin
            failed++; $display("FAIL branch_ready: got %h expected %h",
                               {bus.psel, bus.penable, bus.paddr, ir_valid, IR},
                               {2'b10, 16'h0030, 1'b0, 16'h0000});
        end
        tick(); tick();
        tests++;
        if ({ir_valid, IR, pc} !== {1'b1, 16'h30CF, 16'h0030}) begin
            failed++; $display("FAIL branch_ready_ir: got %h expected %h",
                               {ir_valid, IR, pc}, {1'b1, 16'h30CF, 16'h0030});
        end
    endtask

    task automatic test_wait_states();
        start_at(16'h0005);
        ready_ctl = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) begin
            ready_ctl = (i == 3);
            tests++;
            if ({bus.psel, bus.penable, bus.paddr, ir_valid} !== {2'b11, 16'h0005, 1'b0}) begin
                failed++; $display("FAIL wait_stable%0d: got %h expected %h", i,
                                   {bus.psel, bus.penable, bus.paddr, ir_valid}, {2'b11, 16'h0005, 1'b0});
            end
            tick();
        end
        tests++;
        if ({ir_valid, IR, pc} !== {1'b1, 16'h05FA, 16'h0005}) begin
            failed++; $display("FAIL wait_ir: got %h expected %h",
                               {ir_valid, IR, pc}, {1'b1, 16'h05FA, 16'h0005});
        end
    endtask

    task automatic test_stall_mid();
        start_at(16'h0007);
        stall = 1'b1;
        tick(); tick();
        tests++;
        if ({ir_valid, IR, pc, bus.psel} !== {1'b1, 16'h07F8, 16'h0007, 1'b0}) begin
            failed++; $display("FAIL stall_complete: got %h expected %h",
                               {ir_valid, IR, pc, bus.psel}, {1'b1, 16'h07F8, 16'h0007, 1'b0});
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if ({bus.psel, ir_valid, IR} !== {1'b0, 1'b0, 16'h07F8}) begin
                failed++; $display("FAIL stall_hold%0d: got %h expected %h", i,
                                   {bus.psel, ir_valid, IR}, {1'b0, 1'b0, 16'h07F8});
            end
        end
        stall = 1'b0;
        tick();
        tests++;
        if ({bus.psel, bus.penable, bus.paddr} !== {2'b10, 16'h0008}) begin
            failed++; $display("FAIL stall_resume: got %h expected %h",
                               {bus.psel, bus.penable, bus.paddr}, {2'b10, 16'h0008});
        end
    endtask

    task automatic test_slverr();
        start_at(16'h0009);
        err_ctl = 1'b1;
        tick(); tick();
        err_ctl = 1'b0;
        tests++;
        if ({ir_valid, IR, pc, fetch_err} !== {1'b1, 16'h0000, 16'h0009, 1'b1}) begin
            failed++; $display("FAIL slverr_nop: got %h expected %h",
                               {ir_valid, IR, pc, fetch_err}, {1'b1, 16'h0000, 16'h0009, 1'b1});
        end
        tests++;
        if ({bus.psel, bus.penable, bus.paddr} !== {2'b10, 16'h000A}) begin
            failed++; $display("FAIL slverr_next: got %h expected %h",
                               {bus.psel, bus.penable, bus.paddr}, {2'b10, 16'h000A});
        end
        tick(); tick();
        tests++;
        if ({ir_valid, IR, pc, fetch_err} !== {1'b1, 16'h0AF5, 16'h000A, 1'b1}) begin
            failed++; $display("FAIL slverr_sticky: got %h expected %h",
                               {ir_valid, IR, pc, fetch_err}, {1'b1, 16'h0AF5, 16'h000A, 1'b1});
        end
    endtask

`ifdef CPU_FETCH_TIMEOUT_EN
    task automatic test_timeout();
        start_at(16'h0009);
        ready_ctl = 1'b0; stall = 1'b1;
        tick();
        for (int i = 0; i < TIMEOUT; i++) begin
            tests++;
            if ({bus.psel, bus.penable, bus.paddr, ir_valid} !== {2'b11, 16'h0009, 1'b0}) begin
                failed++; $display("FAIL timeout_wait%0d: got %h expected %h", i,
                                   {bus.psel, bus.penable, bus.paddr, ir_valid}, {2'b11, 16'h0009, 1'b0});
            end
            tick();
        end
        tests++;
        if ({ir_valid, IR, pc, fetch_err, bus.psel, bus.penable} !==
            {1'b1, 16'h0000, 16'h0009, 1'b1, 2'b00}) begin
            failed++; $display("FAIL timeout_end: got %h expected %h",
                               {ir_valid, IR, pc, fetch_err, bus.psel, bus.penable},
                               {1'b1, 16'h0000, 16'h0009, 1'b1, 2'b00});
        end
        ready_ctl = 1'b1; stall = 1'b0;
    endtask
`endif

    task automatic test_wrap_and_reset();
        start_at(16'hFFFF);
        err_ctl = 1'b1;
        tick(); tick();
        err_ctl = 1'b0;
        tests++;
        if ({ir_valid, IR, pc, fetch_err, bus.paddr} !==
            {1'b1, 16'h0000, 16'hFFFF, 1'b1, 16'h0000}) begin
            failed++; $display("FAIL wrap_ffff: got %h expected %h",
                               {ir_valid, IR, pc, fetch_err, bus.paddr},
                               {1'b1, 16'h0000, 16'hFFFF, 1'b1, 16'h0000});
        end
        tick(); tick();
        tests++;
        if ({ir_valid, IR, pc, bus.paddr} !== {1'b1, 16'h2081, 16'h0000, 16'h0001}) begin
            failed++; $display("FAIL wrap_zero: got %h expected %h",
                               {ir_valid, IR, pc, bus.paddr}, {1'b1, 16'h2081, 16'h0000, 16'h0001});
        end
        ready_ctl = 1'b0;
        tick();
        tests++;
        if ({bus.psel, bus.penable, bus.paddr} !== {2'b11, 16'h0001}) begin
            failed++; $display("FAIL wrap_access: got %h expected %h",
                               {bus.psel, bus.penable, bus.paddr}, {2'b11, 16'h0001});
        end
        reset = 1'b0;
        tick();
        tests++;
        if ({bus.psel, bus.penable, bus.pwrite, bus.paddr} !== {3'b000, 16'h0000}) begin
            failed++; $display("FAIL midreset_bus: got %h expected %h",
                               {bus.psel, bus.penable, bus.pwrite, bus.paddr}, {3'b000, 16'h0000});
        end
        tests++;
        if ({IR, ir_valid, pc, fetch_err} !== {16'h0000, 1'b0, 16'h0000, 1'b0}) begin
            failed++; $display("FAIL midreset_out: got %h expected %h",
                               {IR, ir_valid, pc, fetch_err}, {16'h0000, 1'b0, 16'h0000, 1'b0});
        end
        reset = 1'b1; stall = 1'b0; ready_ctl = 1'b1;
        tick();
        tests++;
        if ({bus.psel, bus.penable, bus.paddr} !== {2'b10, 16'h0000}) begin
            failed++; $display("FAIL postreset_setup: got %h expected %h",
                               {bus.psel, bus.penable, bus.paddr}, {2'b10, 16'h0000});
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = {i[7:0], ~i[7:0]};
        mem[0] = 16'h2081; mem[1] = 16'h4112; mem[2] = 16'h6223;

        test_reset();
        test_sequential();
        test_branch_in_access();
        test_branch_at_ready();
        test_wait_states();
        test_stall_mid();
        test_slverr();
`ifdef CPU_FETCH_TIMEOUT_EN
        test_timeout();
`endif
        test_wrap_and_reset();

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
